// File: rtl/slot_reel_controller_if.sv
// Button/tick inputs and reel/speed/result outputs of slot_reel_controller.
// master drives buttons and the divider tick; slave is the controller.
`timescale 1ns/1ps
interface slot_reel_controller_if;
  logic        tick_in;
  logic        spin_btn;
  logic        stop_btn;
  logic [25:0] speed;
  logic [3:0]  reel0;
  logic [3:0]  reel1;
  logic [3:0]  reel2;
  logic        busy;
  logic        win;
  logic        pair;

  modport master (
    output tick_in, spin_btn, stop_btn,
    input  speed, reel0, reel1, reel2, busy, win, pair
  );

  modport slave (
    input  tick_in, spin_btn, stop_btn,
    output speed, reel0, reel1, reel2, busy, win, pair
  );
endinterface

// File: rtl/slot_reel_controller.sv
// Three-reel slot sequencer: synchronised tick/buttons, reel freeze FSM, divider speed ramp.
// Optional SLOT_AUTOSTOP_EN: a step at MIN_SPEED while spinning acts as a stop.
`timescale 1ns/1ps
module slot_reel_controller #(
  parameter int unsigned MAX_SPEED   = 50000000,
  parameter int unsigned START_SPEED = 20,
  parameter int unsigned MIN_SPEED   = 2,
  parameter int unsigned DECEL_STEP  = 1
) (
  input logic                   clk,
  input logic                   rst,
  slot_reel_controller_if.slave reel_if
);

  typedef enum logic [2:0] {StIdle, StSpin, StLock0, StLock1, StResult} state_e;

  localparam int unsigned StartClamp = (START_SPEED > MAX_SPEED) ? MAX_SPEED : START_SPEED;
  localparam logic [25:0] StartSpeed = 26'(StartClamp);
  localparam logic [25:0] MinSpeed   = 26'(MIN_SPEED);
  localparam logic [25:0] DecelStep  = 26'(DECEL_STEP);
  localparam logic [3:0]  ReelInc [3] = '{4'd1, 4'd3, 4'd7};

  // Bit 0 tick, bit 1 spin, bit 2 stop.
  logic [2:0] w_in;
  logic [2:0] r_sync1, r_sync2, r_prev, r_pulse;
  logic       w_step, w_spin, w_stop, w_stop_eff;

  state_e      r_state, w_state_d;
  logic [3:0]  r_reel [3];
  logic [3:0]  w_reel_d [3];
  logic [25:0] r_speed, w_speed_d;
  logic        r_win, w_win_d;
  logic        r_pair, w_pair_d;
  logic        w_spinning;
  logic [1:0]  w_frozen, w_freeze_lim;

  function automatic logic [3:0] reel_adv(input logic [3:0] cur, input logic [3:0] inc);
    logic [4:0] sum;
    sum = {1'b0, cur} + {1'b0, inc};
    return (sum >= 5'd10) ? 4'(sum - 5'd10) : sum[3:0];
  endfunction

  assign w_in = {reel_if.stop_btn, reel_if.spin_btn, reel_if.tick_in};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_prev  <= '0;
      r_pulse <= '0;
    end else begin
      r_sync1 <= w_in;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      r_pulse <= r_sync2 & ~r_prev;
    end
  end

  assign w_step = r_pulse[0];
  assign w_spin = r_pulse[1];
  assign w_stop = r_pulse[2];

  assign w_spinning = (r_state == StSpin) || (r_state == StLock0) || (r_state == StLock1);

`ifdef SLOT_AUTOSTOP_EN
  assign w_stop_eff = w_stop | (w_step & w_spinning & (r_speed == MinSpeed));
`else
  assign w_stop_eff = w_stop;
`endif

  always_comb begin
    w_frozen = 2'd0;
    if (r_state == StLock0) w_frozen = 2'd1;
    if (r_state == StLock1) w_frozen = 2'd2;
  end

  // A reel frozen this cycle must not take a coincident step.
  assign w_freeze_lim = w_frozen + {1'b0, (w_stop_eff & w_spinning)};

  always_comb begin
    w_state_d = r_state;
    w_reel_d  = r_reel;
    w_speed_d = r_speed;
    w_win_d   = r_win;
    w_pair_d  = r_pair;

    unique case (r_state)
      StIdle, StResult: begin
        if (w_spin) begin
          w_state_d = StSpin;
          w_speed_d = StartSpeed;
          w_win_d   = 1'b0;
          w_pair_d  = 1'b0;
        end
      end
      StSpin:  if (w_stop_eff) w_state_d = StLock0;
      StLock0: if (w_stop_eff) w_state_d = StLock1;
      StLock1: if (w_stop_eff) w_state_d = StResult;
      default: w_state_d = StIdle;
    endcase

    if (w_spinning && w_step) begin
      for (int i = 0; i < 3; i++) begin
        if (2'(i) >= w_freeze_lim) w_reel_d[i] = reel_adv(r_reel[i], ReelInc[i]);
      end
      w_speed_d = (r_speed >= MinSpeed + DecelStep) ? r_speed - DecelStep : MinSpeed;
    end

    if (w_spinning && (w_state_d == StResult)) begin
      w_win_d   = (w_reel_d[0] == w_reel_d[1]) && (w_reel_d[1] == w_reel_d[2]);
      w_pair_d  = !w_win_d && ((w_reel_d[0] == w_reel_d[1]) || (w_reel_d[1] == w_reel_d[2])
                               || (w_reel_d[0] == w_reel_d[2]));
      w_speed_d = MinSpeed;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= StIdle;
      r_speed <= MinSpeed;
      r_win   <= 1'b0;
      r_pair  <= 1'b0;
      for (int i = 0; i < 3; i++) r_reel[i] <= 4'd0;
    end else begin
      r_state <= w_state_d;
      r_speed <= w_speed_d;
      r_win   <= w_win_d;
      r_pair  <= w_pair_d;
      for (int i = 0; i < 3; i++) r_reel[i] <= w_reel_d[i];
    end
  end

  assign reel_if.speed = r_speed;
  assign reel_if.reel0 = r_reel[0];
  assign reel_if.reel1 = r_reel[1];
  assign reel_if.reel2 = r_reel[2];
  assign reel_if.busy  = w_spinning;
  assign reel_if.win   = r_win;
  assign reel_if.pair  = r_pair;

endmodule
